sti_res_unpacker: RTL
=====================

Name: sti_res_unpacker

Overview:
- Initiator on the stimulus-ROM / result-RAM interface pair.
- Reads the packed 1-bit binary image from the stimulus ROM: WORDS × 16-bit words, 16 pixels per word, MSB = leftmost pixel.
- Writes one 8-bit pixel per cycle into the result RAM, producing the byte image that the distance-transform passes operate on.
- Runs once per start pulse, then flags done.

Parameters:
- WORDS, 1024: number of 16-bit ROM words per frame. Image is WORDS*16 pixels.
- FG_VAL, 8'h01: byte written for a 1 bit (object pixel).
- BG_VAL, 8'h00: byte written for a 0 bit (background pixel).

Ports:
- clk  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  sampled at posedge in IDLE; 1 starts a frame.
- busy  output  1  high from the cycle after start is accepted until done rises.
- done  output  1  level; high after the final write, cleared when the next start is accepted.
- sti_rd  output  1  ROM read strobe; ROM samples addr and updates data on negedge.
- sti_addr  output  10  ROM word index.
- sti_di  input  16  ROM data; valid at the posedge following the negedge read.
- res_wr  output  1  RAM write enable; RAM writes on posedge.
- res_rd  output  1  RAM read strobe; held 0.
- res_addr  output  14  RAM byte address = {word_idx, pix_idx}.
- res_do  output  8  RAM write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - busy=0, done=0, sti_rd=0, sti_addr=0, res_wr=0, res_rd=0, res_addr=0, res_do=0.
  - word_reg=0, word_idx=0, pix_idx=0.
  - A reset mid-frame aborts immediately. No further writes. RAM contents already written are left as-is.
- All outputs are registered; none is combinational from an input.
- FSM states: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - On posedge with start=1: word_idx=0, go to FETCH.
  - Outputs after that edge: sti_rd=1, sti_addr=0, busy=1, done=0, res_wr=0.
- FETCH (1 cycle):
  - sti_rd=1, sti_addr=word_idx.
  - At the next posedge: word_reg <= sti_di, pix_idx=0, go to WRITE.
  - Outputs after that edge: sti_rd=0, res_wr=1, res_addr={word_idx,4'd0}, res_do = sti_di[15] ? FG_VAL : BG_VAL.
- WRITE (16 cycles):
  - Each cycle res_wr=1, res_addr={word_idx,pix_idx}, res_do = word_reg[15-pix_idx] ? FG_VAL : BG_VAL.
  - The RAM commits at the posedge ending the cycle.
  - pix_idx increments 0→15.
  - At the edge ending pix_idx=15, if word_idx<WORDS-1: word_idx+1, go to FETCH (res_wr=0, sti_rd=1, sti_addr=new word_idx).
  - Otherwise go to DONE.
- DONE:
  - res_wr=0, sti_rd=0, busy=0, done=1.
  - res_addr and sti_addr hold their last values.
  - On posedge with start=1: clear done, restart as from IDLE (FETCH of word 0).
- Timing:
  - Let E0 be the accepting edge. Each word takes exactly 17 cycles.
  - done rises after edge E0 + 17*WORDS (17408 for the default).
- Bit and address mapping:
  - Bit order is MSB first: ROM word w, bit b → RAM address w*16 + (15-b).
  - pix_idx is 4 bits and wraps naturally. word_idx is 10 bits.
- start while busy (FETCH/WRITE): ignored, no restart, no effect on the count.
- start held high continuously: a frame restarts only from IDLE or DONE.
- res_rd is constant 0. No RAM reads are issued.
- Exactly one RAM write per pixel. No duplicate or skipped addresses; res_addr increases strictly by 1 across consecutive write cycles.
- No writes occur outside WRITE.

Test Plan:
- Reset + start, ROM word0=16'h8001, rest 0 → RAM[0]=01, RAM[1..14]=00, RAM[15]=01, RAM[16..16383]=00. done rises after 17408 cycles. busy=0 then.
- ROM all 16'hFFFF → all 16384 RAM bytes = FG_VAL. Monitor confirms 16384 res_wr cycles with res_addr sequence 0..16383, no gaps.
- ROM word 1023 = 16'h0001, others 0 → only RAM[16383]=01. sti_addr never exceeds 1023. No write after done.
- start pulsed again mid-frame (at cycle 500) → ignored; done timing unchanged at 17408.
- reset asserted at cycle 1000 → outputs go to reset values within the same cycle (asynchronously). No res_wr afterwards. A new start runs a full frame correctly.
- After done, ROM reloaded with the checkerboard pattern 16'hAAAA, then start → RAM[even]=01, RAM[odd]=00. done clears on the accepting edge and reasserts 17408 cycles later.

Source files
------------

// File: rtl/sti_res_unpacker.sv
// Unpacks the 1-bit stimulus ROM image into one result-RAM byte per pixel.
// Each word costs one FETCH cycle plus sixteen WRITE cycles.
module sti_res_unpacker #(
   parameter int         WORDS  = 1024,
   parameter logic [7:0] FG_VAL = 8'h01,
   parameter logic [7:0] BG_VAL = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        sti_rd,
   output logic [9:0]  sti_addr,
   input  logic [15:0] sti_di,
   output logic        res_wr,
   output logic        res_rd,
   output logic [13:0] res_addr,
   output logic [7:0]  res_do
);

   typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

   localparam logic [9:0] LAST_WORD = 10'(WORDS - 1);

   state_t      state, state_n;
   logic [9:0]  word_idx, word_n;
   logic [3:0]  pix_idx, pix_n;
   logic [15:0] word_reg, wreg_n;
   logic        busy_n, done_n, rd_n, wr_n;
   logic [9:0]  saddr_n;
   logic [13:0] raddr_n;
   logic [7:0]  do_n;

   assign res_rd = 1'b0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         word_idx <= '0;
         pix_idx  <= '0;
         word_reg <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sti_rd   <= 1'b0;
         sti_addr <= '0;
         res_wr   <= 1'b0;
         res_addr <= '0;
         res_do   <= '0;
      end else begin
         state    <= state_n;
         word_idx <= word_n;
         pix_idx  <= pix_n;
         word_reg <= wreg_n;
         busy     <= busy_n;
         done     <= done_n;
         sti_rd   <= rd_n;
         sti_addr <= saddr_n;
         res_wr   <= wr_n;
         res_addr <= raddr_n;
         res_do   <= do_n;
      end
   end

   // Outputs are registered, so this block computes the values they take after the edge.
   always_comb begin
      state_n = state;
      word_n  = word_idx;
      pix_n   = pix_idx;
      wreg_n  = word_reg;
      busy_n  = busy;
      done_n  = done;
      rd_n    = 1'b0;
      wr_n    = 1'b0;
      saddr_n = sti_addr;
      raddr_n = res_addr;
      do_n    = res_do;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = FETCH;
               word_n  = '0;
               rd_n    = 1'b1;
               saddr_n = '0;
               busy_n  = 1'b1;
               done_n  = 1'b0;
            end
         end
         FETCH: begin
            // ROM data arrives at this edge; pixel 0 is emitted straight from it.
            wreg_n  = sti_di;
            pix_n   = '0;
            state_n = WRITE;
            wr_n    = 1'b1;
            raddr_n = {word_idx, 4'd0};
            do_n    = sti_di[15] ? FG_VAL : BG_VAL;
         end
         WRITE: begin
            if (pix_idx != 4'd15) begin
               pix_n   = pix_idx + 4'd1;
               wr_n    = 1'b1;
               raddr_n = {word_idx, pix_n};
               do_n    = word_reg[~pix_n] ? FG_VAL : BG_VAL;
            end else if (word_idx != LAST_WORD) begin
               word_n  = word_idx + 10'd1;
               state_n = FETCH;
               rd_n    = 1'b1;
               saddr_n = word_n;
            end else begin
               state_n = DONE;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
